// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the decode-stage hazard unit: opcodes,
// scoreboard slot layout and forwarding-select encoding.
package mips_hazard_pkg;

    localparam int CNT_W_DEFAULT = 32;
    localparam int REG_FIELD_W   = 5;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_SUBI = 6'h03;
    localparam logic [5:0] OP_MUL  = 6'h04;
    localparam logic [5:0] OP_MULI = 6'h05;
    localparam logic [5:0] OP_OR   = 6'h06;
    localparam logic [5:0] OP_ORI  = 6'h07;
    localparam logic [5:0] OP_AND  = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h09;
    localparam logic [5:0] OP_XOR  = 6'h0A;
    localparam logic [5:0] OP_XORI = 6'h0B;
    localparam logic [5:0] OP_LDW  = 6'h0C;
    localparam logic [5:0] OP_STW  = 6'h0D;
    localparam logic [5:0] OP_BZ   = 6'h0E;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;

    typedef struct packed {
        logic                   valid;
        logic [REG_FIELD_W-1:0] dest;
        logic                   is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/mips_reg_usage_decode.sv
// Combinational opcode decoder: which register fields an instruction reads,
// which one it writes, and whether it is a load.
module mips_reg_usage_decode
    import mips_hazard_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [31:0]            instr,
    output logic                   uses_rs,
    output logic                   uses_rt,
    output logic [REG_FIELD_W-1:0] rs,
    output logic [REG_FIELD_W-1:0] rt,
    output logic [REG_FIELD_W-1:0] dest,
    output logic                   has_dest,
    output logic                   is_load
);

    // Narrower register files ignore the upper bits of each 5-bit field.
    localparam logic [REG_FIELD_W-1:0] FIELD_MASK = REG_FIELD_W'((1 << RW) - 1);

    logic [5:0]             opcode;
    logic [REG_FIELD_W-1:0] rd;
    logic                   unused_imm;

    assign opcode     = instr[31:26];
    assign rs         = instr[25:21] & FIELD_MASK;
    assign rt         = instr[20:16] & FIELD_MASK;
    assign rd         = instr[15:11] & FIELD_MASK;
    assign unused_imm = ^instr[10:0];

    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        dest    = '0;
        is_load = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                dest    = rd;
            end
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
                uses_rs = 1'b1;
                dest    = rt;
            end
            OP_LDW: begin
                uses_rs = 1'b1;
                dest    = rt;
                is_load = 1'b1;
            end
            OP_STW, OP_BEQ: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BZ, OP_JR: begin
                uses_rs = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Writes to r0 are discarded, so they never create a dependency.
    assign has_dest = (dest != '0);

endmodule

// File: rtl/mips_hazard_unit.sv
// Decode-stage RAW hazard detector: tracks in-flight destinations for
// EX/MEM/WB, stalls ID, optionally registers forwarding selects, counts stalls.
module mips_hazard_unit
    import mips_hazard_pkg::*;
#(
    parameter int REG_NUM    = 32,
    parameter int FORWARDING = 0,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             flush,
    output logic             id_stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] hazard_count
);

    localparam int RW = $clog2(REG_NUM);

    logic                   uses_rs, uses_rt, has_dest, is_load;
    logic [REG_FIELD_W-1:0] rs, rt, dest;

    sb_entry_t  ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    fwd_sel_e   fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic       stalled_q, stalled_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] hazard_count_q, hazard_count_d;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic raw, issue;
    logic unused_wb;

    mips_reg_usage_decode #(.RW(RW)) u_decode (
        .instr    (id_instr),
        .uses_rs  (uses_rs),
        .uses_rt  (uses_rt),
        .rs       (rs),
        .rt       (rt),
        .dest     (dest),
        .has_dest (has_dest),
        .is_load  (is_load)
    );

    // WB is tracked but never consulted: the regfile writes before it reads.
    assign unused_wb = ^wb_q;

    always_comb begin
        ex_hit_rs  = uses_rs && ex_q.valid  && (ex_q.dest  == rs);
        ex_hit_rt  = uses_rt && ex_q.valid  && (ex_q.dest  == rt);
        mem_hit_rs = uses_rs && mem_q.valid && (mem_q.dest == rs);
        mem_hit_rt = uses_rt && mem_q.valid && (mem_q.dest == rt);
        if (FORWARDING != 0) begin
            raw = (ex_hit_rs || ex_hit_rt) && ex_q.is_load;
        end else begin
            raw = ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt;
        end
        id_stall = id_valid && !flush && raw;
        issue    = id_valid && !flush && !raw;
    end

    always_comb begin
        ex_d         = SB_BUBBLE;
        ex_d.valid   = issue && has_dest;
        ex_d.dest    = (issue && has_dest) ? dest : '0;
        ex_d.is_load = issue && has_dest && is_load;
        mem_d        = ex_q;
        wb_d         = mem_q;

        // The youngest producer (EX) takes priority over the older one in MEM.
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (FORWARDING != 0 && issue) begin
            if (ex_hit_rs)       fwd_a_d = FWD_EXMEM;
            else if (mem_hit_rs) fwd_a_d = FWD_MEMWB;
            if (ex_hit_rt)       fwd_b_d = FWD_EXMEM;
            else if (mem_hit_rt) fwd_b_d = FWD_MEMWB;
        end

        if (issue || flush)  stalled_d = 1'b0;
        else if (id_stall)   stalled_d = 1'b1;
        else                 stalled_d = stalled_q;

        stall_count_d  = stall_count_q + {{(CNT_W-1){1'b0}}, id_stall};
        hazard_count_d = hazard_count_q + {{(CNT_W-1){1'b0}}, (id_stall && !stalled_q)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q           <= SB_BUBBLE;
            mem_q          <= SB_BUBBLE;
            wb_q           <= SB_BUBBLE;
            fwd_a_q        <= FWD_RF;
            fwd_b_q        <= FWD_RF;
            stalled_q      <= 1'b0;
            stall_count_q  <= '0;
            hazard_count_q <= '0;
        end else begin
            ex_q           <= ex_d;
            mem_q          <= mem_d;
            wb_q           <= wb_d;
            fwd_a_q        <= fwd_a_d;
            fwd_b_q        <= fwd_b_d;
            stalled_q      <= stalled_d;
            stall_count_q  <= stall_count_d;
            hazard_count_q <= hazard_count_d;
        end
    end

    assign fwd_a_sel    = fwd_a_q;
    assign fwd_b_sel    = fwd_b_q;
    assign stall_count  = stall_count_q;
    assign hazard_count = hazard_count_q;

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Bench for mips_hazard_unit: a stall-only and a forwarding instance side by
// side, checked every cycle against a per-register issue-timestamp model.
module tb_mips_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid_i [2];
    logic [31:0] id_instr_i [2];
    logic        flush_i    [2];
    logic        id_stall_o [2];
    logic [1:0]  fwd_a_o    [2];
    logic [1:0]  fwd_b_o    [2];
    logic [31:0] stall_cnt_o  [2];
    logic [31:0] hazard_cnt_o [2];

    always #5 clk = ~clk;

    mips_hazard_unit #(.FORWARDING(0)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid_i[0]), .id_instr(id_instr_i[0]),
        .flush(flush_i[0]), .id_stall(id_stall_o[0]), .fwd_a_sel(fwd_a_o[0]),
        .fwd_b_sel(fwd_b_o[0]), .stall_count(stall_cnt_o[0]), .hazard_count(hazard_cnt_o[0])
    );

    mips_hazard_unit #(.FORWARDING(1)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid_i[1]), .id_instr(id_instr_i[1]),
        .flush(flush_i[1]), .id_stall(id_stall_o[1]), .fwd_a_sel(fwd_a_o[1]),
        .fwd_b_sel(fwd_b_o[1]), .stall_count(stall_cnt_o[1]), .hazard_count(hazard_cnt_o[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: for each register, the edge at which its latest
    // producer entered EX. Distance 0 = in EX, 1 = in MEM, 2 = in WB.
    int edge_n = 0;
    int issue_edge [2][32];
    bit load_flag  [2][32];
    int m_stall_cnt [2];
    int m_haz_cnt   [2];
    int m_fa [2];
    int m_fb [2];
    bit m_stalled [2];
    bit obs_stall [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int op, input int rd, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rt, input int rs, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, output bit ur, output bit ut,
                                       output int dst, output bit ld);
        int op;
        op  = int'(ins[31:26]);
        ur  = 0;
        ut  = 0;
        dst = 0;
        ld  = 0;
        if (op <= 11) begin
            ur = 1;
            if (op % 2 == 0) begin
                ut  = 1;
                dst = int'(ins[15:11]);
            end else begin
                dst = int'(ins[20:16]);
            end
        end else if (op == 12) begin
            ur  = 1;
            dst = int'(ins[20:16]);
            ld  = 1;
        end else if (op == 13 || op == 15) begin
            ur = 1;
            ut = 1;
        end else if (op == 14 || op == 16) begin
            ur = 1;
        end
    endfunction

    function automatic bit src_hz(input int m, input int r);
        int d;
        d = edge_n - issue_edge[m][r];
        if (m == 0) return (d <= 1);
        return (d == 0) && load_flag[m][r];
    endfunction

    function automatic int src_fwd(input int m, input int r);
        int d;
        d = edge_n - issue_edge[m][r];
        if (d == 0) return 1;
        if (d == 1) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 32; r++) begin
                issue_edge[m][r] = -100;
                load_flag[m][r]  = 0;
            end
            m_stall_cnt[m] = 0;
            m_haz_cnt[m]   = 0;
            m_fa[m]        = 0;
            m_fb[m]        = 0;
            m_stalled[m]   = 0;
            obs_stall[m]   = 0;
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks mid-cycle, then
    // advances the model across the next edge.
    task automatic cycle();
        #3;
        for (int m = 0; m < 2; m++) begin
            bit ur, ut, ld, st, issue;
            int dst, rs, rt, fa, fb;
            ref_decode(id_instr_i[m], ur, ut, dst, ld);
            rs = int'(id_instr_i[m][25:21]);
            rt = int'(id_instr_i[m][20:16]);
            st = id_valid_i[m] && !flush_i[m] && ((ur && src_hz(m, rs)) || (ut && src_hz(m, rt)));
            obs_stall[m] = id_stall_o[m];
            check($sformatf("m%0d id_stall", m), 32'(id_stall_o[m]), 32'(st));
            check($sformatf("m%0d fwd_a", m), 32'(fwd_a_o[m]), 32'(m_fa[m]));
            check($sformatf("m%0d fwd_b", m), 32'(fwd_b_o[m]), 32'(m_fb[m]));
            check($sformatf("m%0d stall_count", m), stall_cnt_o[m], 32'(m_stall_cnt[m]));
            check($sformatf("m%0d hazard_count", m), hazard_cnt_o[m], 32'(m_haz_cnt[m]));
            issue = id_valid_i[m] && !flush_i[m] && !st;
            if (st) begin
                if (!m_stalled[m]) m_haz_cnt[m]++;
                m_stalled[m] = 1;
                m_stall_cnt[m]++;
            end
            if (issue || flush_i[m]) m_stalled[m] = 0;
            fa = 0;
            fb = 0;
            if (issue && m == 1) begin
                if (ur) fa = src_fwd(m, rs);
                if (ut) fb = src_fwd(m, rt);
            end
            m_fa[m] = fa;
            m_fb[m] = fb;
            if (issue && dst != 0) begin
                issue_edge[m][dst] = edge_n + 1;
                load_flag[m][dst]  = ld;
            end
        end
        edge_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int m = 0; m < 2; m++) begin
            id_valid_i[m] = 1'b0;
            id_instr_i[m] = '0;
            flush_i[m]    = 1'b0;
        end
    endtask

    // Asserted between edges; outputs must clear before any edge arrives.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d rst id_stall", m), 32'(id_stall_o[m]), 0);
            check($sformatf("m%0d rst fwd_a", m), 32'(fwd_a_o[m]), 0);
            check($sformatf("m%0d rst fwd_b", m), 32'(fwd_b_o[m]), 0);
            check($sformatf("m%0d rst stall_count", m), stall_cnt_o[m], 0);
            check($sformatf("m%0d rst hazard_count", m), hazard_cnt_o[m], 0);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_instr(input int m, input logic [31:0] ins, output int stalls);
        bit done;
        idle_inputs();
        id_valid_i[m] = 1'b1;
        id_instr_i[m] = ins;
        stalls = 0;
        done   = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (!obs_stall[m]) begin
                done = 1;
                break;
            end
            stalls++;
        end
        check($sformatf("m%0d issue_timeout", m), 32'(done), 1);
        idle_inputs();
    endtask

    initial begin
        int s;
        reset = 1'b1;
        idle_inputs();
        do_reset();

        // Stall-only: back-to-back dependency costs two cycles.
        run_instr(0, r_ins(8'h00, 3, 1, 2), s);
        check("t1 add stalls", 32'(s), 0);
        run_instr(0, r_ins(8'h02, 4, 3, 1), s);
        check("t1 sub stalls", 32'(s), 2);
        check("t1 stall_count", stall_cnt_o[0], 2);
        check("t1 hazard_count", hazard_cnt_o[0], 1);

        // Stall-only: one unrelated instruction in between leaves one stall.
        do_reset();
        run_instr(0, r_ins(8'h00, 3, 1, 2), s);
        run_instr(0, i_ins(8'h07, 5, 6, 1), s);
        run_instr(0, r_ins(8'h08, 7, 3, 1), s);
        check("t2 and stalls", 32'(s), 1);
        check("t2 stall_count", stall_cnt_o[0], 1);
        check("t2 hazard_count", hazard_cnt_o[0], 1);

        // Forwarding: load-use stalls once, then both operands come from MEM/WB.
        do_reset();
        run_instr(1, i_ins(8'h0C, 2, 1, 0), s);
        run_instr(1, r_ins(8'h00, 4, 2, 2), s);
        check("t3 load-use stalls", 32'(s), 1);
        check("t3 fwd_a", 32'(fwd_a_o[1]), 2);
        check("t3 fwd_b", 32'(fwd_b_o[1]), 2);
        run_instr(1, i_ins(8'h01, 2, 1, 9), s);
        run_instr(1, r_ins(8'h00, 4, 2, 0), s);
        check("t3 alu-use stalls", 32'(s), 0);
        check("t3 alu fwd_a", 32'(fwd_a_o[1]), 1);
        check("t3 alu fwd_b", 32'(fwd_b_o[1]), 0);
        check("t3 stall_count", stall_cnt_o[1], 1);
        check("t3 hazard_count", hazard_cnt_o[1], 1);

        // r0 destination never creates a hazard or a forward.
        for (int m = 0; m < 2; m++) begin
            do_reset();
            run_instr(m, i_ins(8'h01, 0, 1, 5), s);
            run_instr(m, r_ins(8'h00, 2, 0, 0), s);
            check($sformatf("t4 m%0d r0 stalls", m), 32'(s), 0);
            check($sformatf("t4 m%0d fwd_a", m), 32'(fwd_a_o[m]), 0);
            check($sformatf("t4 m%0d fwd_b", m), 32'(fwd_b_o[m]), 0);
            check($sformatf("t4 m%0d stall_count", m), stall_cnt_o[m], 0);
            check($sformatf("t4 m%0d hazard_count", m), hazard_cnt_o[m], 0);
        end

        // Flush on what would be the first stall cycle wins.
        do_reset();
        run_instr(0, r_ins(8'h00, 3, 1, 2), s);
        id_valid_i[0] = 1'b1;
        id_instr_i[0] = i_ins(8'h0F, 1, 3, 0);
        flush_i[0]    = 1'b1;
        cycle();
        check("t5 flush id_stall", 32'(obs_stall[0]), 0);
        idle_inputs();
        for (int k = 0; k < 3; k++) cycle();
        check("t5 stall_count", stall_cnt_o[0], 0);
        check("t5 hazard_count", hazard_cnt_o[0], 0);

        // Asynchronous reset in the middle of a stall.
        do_reset();
        run_instr(0, r_ins(8'h00, 3, 1, 2), s);
        id_valid_i[0] = 1'b1;
        id_instr_i[0] = i_ins(8'h0F, 1, 3, 0);
        cycle();
        check("t6 stalling", 32'(obs_stall[0]), 1);
        check("t6 pre-reset stall_count", stall_cnt_o[0], 1);
        do_reset();
        run_instr(0, i_ins(8'h0F, 1, 3, 0), s);
        check("t6 post-reset stalls", 32'(s), 0);
        check("t6 stall_count", stall_cnt_o[0], 0);
        check("t6 hazard_count", hazard_cnt_o[0], 0);

        // Random traffic; a stalled instruction is held in ID until it issues.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if (k == 750) do_reset();
            for (int m = 0; m < 2; m++) begin
                if (!obs_stall[m]) begin
                    id_valid_i[m] = ($urandom_range(0, 3) != 0);
                    id_instr_i[m] = {6'($urandom_range(0, 19)), 5'($urandom_range(0, 7)),
                                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                     11'($urandom)};
                end
                flush_i[m] = ($urandom_range(0, 15) == 0);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_hazard_unit.md
Name: mips_hazard_unit

Overview:
- Reader side of the decode-stage register-read buffers. Consumes the instruction sitting in ID, tracks in-flight destination registers for EX/MEM/WB, and asserts a stall on RAW hazards.
- Optionally produces registered operand-forwarding selects.
- Owns the pipeline's stall and data-hazard statistics counters.
- Sits beside decode; fetch/decode hold on id_stall, and execute consumes bubbles and forwarding selects.

Parameters:
- REG_NUM, 32, architectural register count; RW = $clog2(REG_NUM).
- FORWARDING, 0, 0 = stall-only pipeline; 1 = full forwarding, stall only on load-use.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction this cycle.
- id_instr  in  32  MIPS-lite instruction word in ID ({opcode[31:26], rs[25:21], rt[20:16], rd[15:11] or imm[15:0]}).
- flush  in  1  taken branch/jump resolved in EX; kill ID and EX.
- id_stall  out  1  hold PC and IF/ID; insert bubble into EX.
- fwd_a_sel  out  2  for instruction now in EX, operand rs source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result.
- fwd_b_sel  out  2  same for rt.
- stall_count  out  CNT_W  total stall cycles.
- hazard_count  out  CNT_W  instructions that incurred at least one stall.

Behaviour:
Interface:
- One clock. Reset is asynchronous and active-high. Clock is clk, reset is reset.

Decode:
- Source and destination are combinational from opcode.
- R-type (ADD 0x00, SUB 0x02, MUL 0x04, OR 0x06, AND 0x08, XOR 0x0A): sources rs, rt; dest rd.
- I-type ALU (odd opcodes 0x01-0x0B) and LDW 0x0C: source rs; dest rt.
- STW 0x0D, BEQ 0x0F: sources rs, rt; no dest.
- BZ 0x0E, JR 0x10: source rs; no dest.
- HALT 0x11 and undefined opcodes: no sources, no dest.
- Dest r0 is treated as no dest: never a hazard, never forwarded.

Scoreboard:
- Three slots: ex_q, mem_q, wb_q, each {valid, dest, is_load}.
- Every cycle: wb_q<=mem_q and mem_q<=ex_q.
- ex_q<=decoded ID entry if id_valid && !id_stall && !flush; otherwise ex_q<=bubble (valid=0).

Stall rule (combinational from registered slots, zero latency):
- FORWARDING=0: stall if any ID source equals a valid dest in ex_q or mem_q. The regfile writes in the first half and reads in the second, so wb_q never causes a stall. A match in ex_q produces 2 stall cycles; a match only in mem_q produces 1.
- FORWARDING=1: stall only if an ID source equals ex_q.dest and ex_q.is_load. This produces exactly 1 stall cycle.
- id_stall=0 whenever id_valid=0 or flush=1 (flush wins over stall).

Forwarding selects (FORWARDING=1):
- Registered when ID issues into EX; valid during that instruction's EX cycle.
- For each source: 1 if it matches ex_q.dest (youngest wins), else 2 if it matches mem_q.dest, else 0.
- Value 0 on bubbles, on flush, and always when FORWARDING=0.

Counters (wrap at 2^CNT_W):
- stall_count += 1 each cycle id_stall=1.
- hazard_count += 1 on the first stall cycle of an ID instruction, tracked by a stalled_q flag set on stall and cleared on issue/flush.

Reset (asynchronous):
- All slots invalid; stalled_q=0; fwd selects 0; counters 0.
- id_stall=0 combinationally after reset.
- Reset mid-stall discards the pending hazard; no count is recorded.

Decomposition:
- Shared package: opcode localparams, scoreboard-entry packed struct {valid, dest[RW-1:0], is_load}, forwarding-select enum {FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2}, CNT_W default.
- One sub-module: mips_reg_usage_decode, a combinational opcode decoder giving {uses_rs, uses_rt, dest, has_dest, is_load}. It is reused by decode and the statistics logic.

Test Plan:
- FORWARDING=0: ADD r3,r1,r2 then SUB r4,r3,r1 back-to-back -> id_stall high 2 cycles; stall_count=2, hazard_count=1; SUB enters EX on the third cycle after ADD's EX.
- FORWARDING=0: ADD r3 then unrelated ORI r5,r6 then AND r7,r3,r1 -> 1 stall cycle; stall_count=1, hazard_count=1.
- FORWARDING=1: LDW r2,0(r1) then ADD r4,r2,r2 -> 1 stall; ADD's EX cycle shows fwd_a_sel=fwd_b_sel=2. ADDI r2 then ADD r4,r2,r0 -> no stall, fwd_a_sel=1.
- ADDI r0,r1,5 then ADD r2,r0,r0 -> no stall in either mode; fwd selects 0; counters unchanged.
- Stall in progress (ADD r3 then BEQ r3,r1) with flush asserted on the first stall cycle -> id_stall=0 that cycle, ex_q bubble; stall_count=0 unchanged, and hazard_count stays 0 because the flush wins.
- Assert reset asynchronously mid-stall (between clock edges) -> id_stall drops immediately, counters read 0, fwd selects 0; the next instruction (no hazard) issues without stalling.
